// File: rtl/jk_op_arbiter.sv
// jk_op_arbiter
//   Two-requester round-robin arbiter in front of one shared JK flip-flop.
//   A granted requester's 2-bit opcode (00 hold, 01 reset, 10 set, 11 toggle)
//   is latched in IDLE. It drives J/K for the single APPLY cycle. It is then
//   acknowledged in RESP with the updated Q. Each operation takes exactly three
//   cycles (IDLE sample, APPLY, RESP).
//
// Parameters
//   RR_INIT   requester favoured first after reset (0 or 1)
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   req0/op0  requester 0 request level and opcode
//   req1/op1  requester 1 request level and opcode
//   gnt0/1    grant pulse, high during APPLY for the selected requester
//   ack0/1    completion pulse, high during RESP; Q is valid then
//   J/K       drive to the shared JK element (non-zero only in APPLY)
//   Q/Qb      shared flip-flop state and its complement
//   busy      high whenever the FSM is not IDLE
//   ops_done  8-bit wrapping count of completed operations
module jk_op_arbiter #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [1:0] op0,
  input  logic       req1,
  input  logic [1:0] op1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       ack0,
  output logic       ack1,
  output logic       J,
  output logic       K,
  output logic       Q,
  output logic       Qb,
  output logic       busy,
  output logic [7:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       sel_q, sel_d;    // selected requester (0/1)
  logic [1:0] op_q, op_d;      // latched opcode of the selected requester
  logic       rr_q, rr_d;      // requester favoured on contention
  logic       q_q, q_d;
  logic [7:0] ops_q, ops_d;
  logic       t_w;

  localparam logic RR_RESET = (RR_INIT != 0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    op_d    = op_q;
    rr_d    = rr_q;
    ops_d   = ops_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Contention goes to the pointer; otherwise to the lone requester.
          if (req0 && req1) begin
            sel_d = rr_q;
          end else begin
            sel_d = req1;
          end
          op_d    = sel_d ? op1 : op0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        state_d = RESP;
      end
      RESP: begin
        rr_d    = ~sel_q;
        ops_d   = ops_q + 8'd1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    ack0 = 1'b0;
    ack1 = 1'b0;
    J    = 1'b0;
    K    = 1'b0;
    busy = (state_q != IDLE);
    if (state_q == APPLY) begin
      gnt0 = ~sel_q;
      gnt1 = sel_q;
      unique case (op_q)
        2'b00: begin J = 1'b0; K = 1'b0; end
        2'b01: begin J = 1'b0; K = 1'b1; end
        2'b10: begin J = 1'b1; K = 1'b0; end
        default: begin J = 1'b1; K = 1'b1; end
      endcase
    end
    if (state_q == RESP) begin
      ack0 = ~sel_q;
      ack1 = sel_q;
    end
  end

  // JK element realised as a T flip-flop; J/K are zero outside APPLY,
  // so it only changes on the edge that ends APPLY.
  assign t_w = (J & ~q_q) | (K & q_q);
  assign q_d = q_q ^ t_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= 1'b0;
      op_q  <= '0;
      rr_q  <= RR_RESET;
      q_q   <= 1'b0;
      ops_q <= '0;
    end else begin
      sel_q <= sel_d;
      op_q  <= op_d;
      rr_q  <= rr_d;
      q_q   <= q_d;
      ops_q <= ops_d;
    end
  end

  assign Q        = q_q;
  assign Qb       = ~q_q;
  assign ops_done = ops_q;

endmodule

// File: tb/tb_jk_op_arbiter.sv
// tb_jk_op_arbiter
//   Directed plus randomized bench for jk_op_arbiter. A transaction-level
//   model tracks Q, the completed-op count and the favoured requester, and
//   predicts every grant, J/K drive, ack and Q value.
module tb_jk_op_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] op0 = 2'b00, op1 = 2'b00;
  logic       gnt0, gnt1, ack0, ack1, J, K, Q, Qb, busy;
  logic [7:0] ops_done;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic       mq;
  logic [7:0] mops;
  logic       mrr;

  jk_op_arbiter #(.RR_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .req1(req1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .J(J), .K(K), .Q(Q), .Qb(Qb), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result of an opcode applied to a JK flip-flop holding q.
  function automatic logic next_q(input logic [1:0] op, input logic q);
    case (op)
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  // J/K pair for an opcode, as {J,K}.
  function automatic logic [1:0] jk_of(input logic [1:0] op);
    case (op)
      2'b00:   return 2'b00;
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic model_reset();
    mq   = 1'b0;
    mops = 8'd0;
    mrr  = 1'b0;
  endtask

  task automatic disturb(input int mode);
    if (mode == 1) begin
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      op0  = 2'($urandom_range(0, 3));
      op1  = 2'($urandom_range(0, 3));
    end else if (mode == 2) begin
      op0 = 2'b01;
    end
  endtask

  // Called while the DUT is in IDLE, away from the clock edge.
  // mode: 0 quiet, 1 randomize inputs in APPLY/RESP, 2 change op0 to 01 in APPLY.
  task automatic run_op(input logic r0, input logic [1:0] o0,
                        input logic r1, input logic [1:0] o1, input int mode);
    logic       win;
    logic [1:0] wop;
    logic       qn;
    req0 = r0; op0 = o0; req1 = r1; op1 = o1;
    check("idle_busy", {7'd0, busy}, 8'd0);
    if (!r0 && !r1) begin
      @(posedge clk); #1;
      check("noreq_busy", {7'd0, busy}, 8'd0);
      check("noreq_gnt", {6'd0, gnt1, gnt0}, 8'd0);
      check("noreq_jk", {6'd0, J, K}, 8'd0);
      return;
    end
    win = (r0 && r1) ? mrr : r1;
    wop = win ? o1 : o0;
    qn  = next_q(wop, mq);
    @(posedge clk); #1;
    check("apply_gnt", {6'd0, gnt1, gnt0}, win ? 8'd2 : 8'd1);
    check("apply_ack", {6'd0, ack1, ack0}, 8'd0);
    check("apply_jk", {6'd0, J, K}, {6'd0, jk_of(wop)});
    check("apply_q", {7'd0, Q}, {7'd0, mq});
    check("apply_busy", {7'd0, busy}, 8'd1);
    disturb(mode);
    @(posedge clk); #1;
    check("resp_ack", {6'd0, ack1, ack0}, win ? 8'd2 : 8'd1);
    check("resp_gnt", {6'd0, gnt1, gnt0}, 8'd0);
    check("resp_jk", {6'd0, J, K}, 8'd0);
    check("resp_q", {6'd0, Q, Qb}, {6'd0, qn, ~qn});
    check("resp_ops", ops_done, mops);
    mq   = qn;
    mops = mops + 8'd1;
    mrr  = ~win;
    if (mode == 1) disturb(1);
    @(posedge clk); #1;
    check("done_busy", {7'd0, busy}, 8'd0);
    check("done_ack", {6'd0, ack1, ack0}, 8'd0);
    check("done_ops", ops_done, mops);
    check("done_q", {7'd0, Q}, {7'd0, mq});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_q", {6'd0, Q, Qb}, 8'd1);
    check("rst_ops", ops_done, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_out", {2'd0, gnt0, gnt1, ack0, ack1, J, K}, 8'd0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    // Reset state
    @(posedge clk); #1;
    check("por_q", {6'd0, Q, Qb}, 8'd1);
    check("por_ops", ops_done, 8'd0);
    check("por_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single requester: set, reset, toggle, hold
    run_op(1'b1, 2'b10, 1'b0, 2'b00, 0);
    run_op(1'b1, 2'b01, 1'b0, 2'b00, 0);
    run_op(1'b1, 2'b11, 1'b0, 2'b00, 0);
    run_op(1'b1, 2'b00, 1'b0, 2'b00, 0);
    check("seq_ops", ops_done, 8'd4);
    check("seq_q", {7'd0, Q}, 8'd1);

    // Contention from a fresh reset: grants 0,1,0,1 and Q 1,0,1,0
    pulse_reset();
    for (int i = 0; i < 4; i++) run_op(1'b1, 2'b11, 1'b1, 2'b11, 0);
    check("cont_q", {7'd0, Q}, 8'd0);

    // Opcode changed to reset during APPLY; latched set still applies
    pulse_reset();
    run_op(1'b1, 2'b10, 1'b0, 2'b00, 2);
    check("late_op_q", {7'd0, Q}, 8'd1);

    // Idle with no request
    run_op(1'b0, 2'b11, 1'b0, 2'b11, 0);

    // Randomized traffic with inputs disturbed mid-operation
    for (int i = 0; i < 80; i++) begin
      run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1);
    end

    // Asynchronous reset mid-run (checked before any clock edge)
    pulse_reset();

    // Abort: reset during APPLY of a set
    req0 = 1'b1; op0 = 2'b10; req1 = 1'b0; op1 = 2'b00;
    @(posedge clk); #1;
    check("abort_gnt", {6'd0, gnt1, gnt0}, 8'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_q", {7'd0, Q}, 8'd0);
    check("abort_busy", {7'd0, busy}, 8'd0);
    req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_noack", {6'd0, ack1, ack0}, 8'd0);
      check("abort_ops", ops_done, 8'd0);
      check("abort_qhold", {7'd0, Q}, 8'd0);
    end
    model_reset();
    run_op(1'b1, 2'b10, 1'b0, 2'b00, 0);
    check("after_abort_q", {7'd0, Q}, 8'd1);

    // Counter wrap: 256 holds return ops_done to its start, Q unchanged
    begin
      logic [7:0] start_ops;
      logic       start_q;
      start_ops = mops;
      start_q   = mq;
      for (int i = 0; i < 256; i++) begin
        run_op(1'($urandom_range(0, 1)), 2'b00, 1'b1, 2'b00, 0);
      end
      check("wrap_ops", ops_done, start_ops);
      check("wrap_q", {7'd0, Q}, {7'd0, start_q});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
